// File: rtl/mem_access_pkg.sv
// Shared types and constants for the LEGv8 data-memory access unit.
package mem_access_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned LANES      = 8;
    localparam int unsigned OFF_W      = 3;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_BUSY = 2'd1,
        MA_DONE = 2'd2
    } ma_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    typedef struct packed {
        logic                  we;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [LANES-1:0]      wstrb;
    } bus_cmd_t;

    // An access is aligned when its byte offset is a multiple of its size.
    function automatic logic is_misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = off[0];
            SIZE_W:  mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// Byte-lane steering: store mask/shift and load extract/extend for one offset and size.
module mem_access_lane_align
    import mem_access_pkg::*;
(
    input  logic [OFF_W-1:0]      offset,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [LANES-1:0]      mask_c,
    output logic [DATA_WIDTH-1:0] wdata_c,
    output logic [DATA_WIDTH-1:0] load_c
);

    logic [5:0]            shamt;
    logic [LANES-1:0]      base_mask;
    logic [DATA_WIDTH-1:0] lane;

    always_comb begin
        shamt     = {offset, 3'b000};
        base_mask = 8'h01;
        lane      = rdata >> shamt;
        load_c    = lane;
        case (size)
            SIZE_B: begin
                base_mask = 8'h01;
                load_c    = {{56{sign_ext & lane[7]}}, lane[7:0]};
            end
            SIZE_H: begin
                base_mask = 8'h03;
                load_c    = {{48{sign_ext & lane[15]}}, lane[15:0]};
            end
            SIZE_W: begin
                base_mask = 8'h0F;
                load_c    = {{32{sign_ext & lane[31]}}, lane[31:0]};
            end
            default: begin
                base_mask = 8'hFF;
                load_c    = lane;
            end
        endcase
        mask_c  = base_mask << offset;
        wdata_c = store_data << shamt;
    end

endmodule

// File: rtl/mem_access.sv
// Single-outstanding load/store bus master that stalls the core until the access retires.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    output logic                  stall,
    output logic                  done,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [LANES-1:0]      bus_wstrb,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    ma_state_e        state_q, state_d;
    logic [TO_W-1:0]  cnt_q;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       size_q;
    logic             sext_q;
    logic             is_load_q;
    bus_cmd_t         cmd_q;

    logic req, illegal, misal;
    logic accept, reject, ack_ok, timeout;

    logic [OFF_W-1:0]      al_off;
    logic [1:0]            al_size;
    logic [LANES-1:0]      mask_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [DATA_WIDTH-1:0] load_c;

    assign req     = mem_read | mem_write;
    assign illegal = mem_read & mem_write;
    assign misal   = is_misaligned(address[OFF_W-1:0], size);

    // Store steering uses the live request; load extraction uses the offset held since accept.
    assign al_off  = (state_q == MA_BUSY) ? off_q  : address[OFF_W-1:0];
    assign al_size = (state_q == MA_BUSY) ? size_q : size;

    mem_access_lane_align u_lane_align (
        .offset     (al_off),
        .size       (al_size),
        .sign_ext   (sext_q),
        .store_data (store_data),
        .rdata      (bus_rdata),
        .mask_c     (mask_c),
        .wdata_c    (wdata_c),
        .load_c     (load_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= MA_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        ack_ok  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            MA_IDLE: begin
                if (req) begin
                    if (illegal || misal) begin
                        reject  = 1'b1;
                        state_d = MA_DONE;
                    end else begin
                        accept  = 1'b1;
                        state_d = MA_BUSY;
                    end
                end
            end
            MA_BUSY: begin
                if (bus_ack) begin
                    ack_ok  = 1'b1;
                    state_d = MA_DONE;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = MA_DONE;
                end
            end
            MA_DONE: state_d = MA_IDLE;
            default: state_d = MA_IDLE;
        endcase
    end

    assign stall = reset & (((state_q == MA_IDLE) & req & ~misal & ~illegal) | (state_q == MA_BUSY));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            off_q     <= '0;
            size_q    <= '0;
            sext_q    <= 1'b0;
            is_load_q <= 1'b0;
            cmd_q     <= '0;
            bus_req   <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            load_data <= '0;
        end else begin
            done  <= (state_d == MA_DONE);
            fault <= reject | timeout;
            if (accept) begin
                bus_req     <= 1'b1;
                cnt_q       <= '0;
                off_q       <= address[OFF_W-1:0];
                size_q      <= size;
                sext_q      <= sign_ext;
                is_load_q   <= mem_read;
                cmd_q.we    <= mem_write;
                cmd_q.addr  <= {address[DATA_WIDTH-1:OFF_W], 3'b000};
                cmd_q.wdata <= wdata_c;
                cmd_q.wstrb <= mem_write ? mask_c : '0;
            end
            if (state_q == MA_BUSY && !ack_ok && !timeout) cnt_q <= cnt_q + TO_W'(1);
            if (ack_ok || timeout) bus_req <= 1'b0;
            if (ack_ok && is_load_q) load_data <= load_c;
            if (timeout) load_data <= '0;
        end
    end

    assign bus_we    = cmd_q.we;
    assign bus_addr  = cmd_q.addr;
    assign bus_wdata = cmd_q.wdata;
    assign bus_wstrb = cmd_q.wstrb;

endmodule

// File: tb/tb_mem_access.sv
// Randomised self-checking bench for mem_access against a byte-level access model.
module tb_mem_access;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] address, store_data, bus_rdata;
    logic        mem_read, mem_write, sign_ext, bus_ack;
    logic [1:0]  size;
    logic        stall, done, fault, bus_req, bus_we;
    logic [63:0] load_data, bus_addr, bus_wdata;
    logic [7:0]  bus_wstrb;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_load = '0;

    mem_access dut (
        .clk(clk), .reset(reset), .address(address), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write), .size(size), .sign_ext(sign_ext),
        .stall(stall), .done(done), .fault(fault), .load_data(load_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_load(input logic [63:0] rd, input int off, input int n, input logic sx);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (sx && n < 8 && v[8*n-1])
            for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] model_strb(input int off, input int n);
        logic [7:0] s = '0;
        for (int i = 0; i < n; i++) s[off+i] = 1'b1;
        return s;
    endfunction

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; address = '0; store_data = '0;
        size = 2'b00; sign_ext = 0; bus_ack = 0; bus_rdata = '0;
    endtask

    // One full access; lat = BUSY cycle index that carries bus_ack, or -1 for never.
    task automatic run_access(input string nm, input logic rd, input logic wr, input logic [63:0] addr,
                              input logic [63:0] sdata, input logic [1:0] sz, input logic sx,
                              input int lat, input logic [63:0] rdata);
        int  n   = 1 << sz;
        int  off = int'(addr[2:0]);
        bit  pre_fault = (rd && wr) || (off % n != 0);
        bit  to  = !(lat >= 0 && lat < TIMEOUT);
        int  exp_cycles = to ? TIMEOUT : lat + 1;
        int  k = 0;
        logic [63:0] exp_wd = sdata << (8 * off);
        mem_read = rd; mem_write = wr; address = addr; store_data = sdata; size = sz; sign_ext = sx;
        #1;
        total++;
        if (stall !== !pre_fault) begin bad++; $display("FAIL %s stall_at_request got=%b exp=%b", nm, stall, !pre_fault); end
        if (pre_fault) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b1 || fault !== 1'b1 || bus_req !== 1'b0 || stall !== 1'b0) begin
                bad++; $display("FAIL %s reject done/fault/req/stall got=%b%b%b%b exp=1100", nm, done, fault, bus_req, stall);
            end
            total++;
            if (load_data !== exp_load) begin bad++; $display("FAIL %s reject load_data got=%h exp=%h", nm, load_data, exp_load); end
        end else begin
            @(posedge clk); #1;
            total++;
            if (bus_req !== 1'b1 || bus_we !== wr || bus_addr !== {addr[63:3], 3'b000}) begin
                bad++; $display("FAIL %s bus_cmd req=%b we=%b addr=%h exp 1 %b %h", nm, bus_req, bus_we, bus_addr, wr, {addr[63:3], 3'b000});
            end
            if (wr) begin
                total++;
                if (bus_wstrb !== model_strb(off, n) || bus_wdata !== exp_wd) begin
                    bad++; $display("FAIL %s store_lanes strb=%h wdata=%h exp %h %h", nm, bus_wstrb, bus_wdata, model_strb(off, n), exp_wd);
                end
            end
            while (done !== 1'b1 && k < TIMEOUT + 4) begin
                total++;
                if (stall !== 1'b1 || bus_req !== 1'b1) begin bad++; $display("FAIL %s busy_cycle%0d stall=%b req=%b exp 11", nm, k, stall, bus_req); end
                bus_ack = (k == lat);
                bus_rdata = (k == lat) ? rdata : 64'(~rdata);
                @(posedge clk); #1;
                bus_ack = 0;
                k++;
            end
            if (!to && rd) exp_load = model_load(rdata, off, n, sx);
            if (to) exp_load = '0;
            total++;
            if (k !== exp_cycles) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, k, exp_cycles); end
            total++;
            if (done !== 1'b1 || fault !== to || bus_req !== 1'b0 || stall !== 1'b0) begin
                bad++; $display("FAIL %s completion done/fault/req/stall got=%b%b%b%b exp=1%b00", nm, done, fault, bus_req, stall, to);
            end
            total++;
            if (load_data !== exp_load) begin bad++; $display("FAIL %s load_data got=%h exp=%h", nm, load_data, exp_load); end
        end
        clear_inputs();
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || fault !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL %s after_done done/fault/stall got=%b%b%b exp=000", nm, done, fault, stall);
        end
    endtask

    task automatic test_reset();
        reset = 0; clear_inputs(); mem_read = 1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (stall !== 0 || done !== 0 || fault !== 0 || bus_req !== 0 || bus_we !== 0) begin
            bad++; $display("FAIL reset ctrl stall/done/fault/req/we got=%b%b%b%b%b exp=00000", stall, done, fault, bus_req, bus_we);
        end
        total++;
        if (load_data !== 0 || bus_addr !== 0 || bus_wdata !== 0 || bus_wstrb !== 0) begin
            bad++; $display("FAIL reset data ld=%h addr=%h wd=%h strb=%h exp all 0", load_data, bus_addr, bus_wdata, bus_wstrb);
        end
        clear_inputs(); reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load();
        run_access("word_load_sx", 1, 0, 64'h104, '0, 2'b10, 1, 0, 64'h80000001_00000000);
        total++;
        if (exp_load !== 64'hFFFFFFFF_80000001) begin bad++; $display("FAIL word_load model got=%h exp=ffffffff80000001", exp_load); end
    endtask

    task automatic test_byte_store();
        run_access("byte_store", 0, 1, 64'h23, 64'hAB, 2'b00, 0, 2, '0);
    endtask

    task automatic test_faults();
        run_access("half_misaligned", 1, 0, 64'h11, '0, 2'b01, 0, 0, '0);
        run_access("dword_misaligned_store", 0, 1, 64'h204, 64'h1234, 2'b11, 0, 0, '0);
        run_access("rd_and_wr", 1, 1, 64'h40, 64'h55, 2'b11, 0, 0, '0);
    endtask

    task automatic test_timeout();
        run_access("dword_timeout", 1, 0, 64'h3000, '0, 2'b11, 1, -1, '0);
    endtask

    task automatic test_idle_ack_ignored();
        bus_ack = 1; bus_rdata = 64'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done !== 0 || fault !== 0 || bus_req !== 0 || stall !== 0 || load_data !== exp_load) begin
            bad++; $display("FAIL idle_ack done/fault/req/stall got=%b%b%b%b ld=%h exp 0000 %h", done, fault, bus_req, stall, load_data, exp_load);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        mem_read = 1; address = 64'h48; size = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        #1;
        total++;
        if (stall !== 0) begin bad++; $display("FAIL reset_mid_busy stall_in_reset got=%b exp=0", stall); end
        @(posedge clk); #1;
        total++;
        if (bus_req !== 0 || stall !== 0 || done !== 0) begin
            bad++; $display("FAIL reset_mid_busy req/stall/done got=%b%b%b exp=000", bus_req, stall, done);
        end
        clear_inputs(); reset = 1;
        exp_load = '0;
        @(posedge clk); #1;
        total++;
        if (done !== 0 || bus_req !== 0) begin bad++; $display("FAIL reset_mid_busy late_done done/req got=%b%b exp=00", done, bus_req); end
        run_access("byte_load_after_reset", 1, 0, 64'h57, '0, 2'b00, 1, 1, 64'h8100_0000_0000_0000);
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            logic [63:0] a   = {$urandom, $urandom};
            logic [63:0] sd  = {$urandom, $urandom};
            logic [63:0] rdv = {$urandom, $urandom};
            logic        wr  = 1'($urandom_range(0, 1));
            logic        rd  = !wr;
            int          lat = $urandom_range(0, 5);
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'(a[2:0] & ~3'((1 << sz) - 1));
            if ($urandom_range(0, 15) == 0) rd = 1;
            if ($urandom_range(0, 9) == 0) lat = -1;
            run_access("random", rd, wr, a, sd, sz, 1'($urandom_range(0, 1)), lat, rdv);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_word_load();
        test_byte_store();
        test_faults();
        test_timeout();
        test_idle_ack_ignored();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
